// File: rtl/execute_multdiv.sv
// Iterative signed multiply/divide for the execute stage: 32-cycle shift-add multiply and restoring divide.
// Define MULTDIV_DIV_EN to build the divider; without it DIV_CODE completes at once with an exception.
module execute_multdiv #(
    parameter logic [4:0] MUL_CODE = 5'b00110,
    parameter logic [4:0] DIV_CODE = 5'b00111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  ALUCode,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    output logic        busy,
    output logic        result_ready,
    output logic [31:0] result,
    output logic        exception
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

    stateT       state;
    logic [4:0]  iterCount;
    logic        negResult;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    logic        isMul;
    logic        isDiv;
    logic        accept;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [63:0] accNext;
    logic [63:0] prodSigned;
    logic        mulOvf;

`ifdef MULTDIV_DIV_EN
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [32:0] remShift;
    logic [32:0] remDiff;
    logic        quoBit;
    logic [31:0] remNext;
    logic [31:0] quoNext;
    logic [31:0] quoSigned;
    logic        divOvf;
`endif

    // 0x80000000 maps to 2^31, which still fits an unsigned 32-bit magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic [63:0] applySign64(input logic [63:0] v, input logic neg);
        return neg ? (64'd0 - v) : v;
    endfunction

    function automatic logic [31:0] applySign32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    function automatic logic fitsSigned32(input logic [63:0] v);
        return (&v[63:31]) | ~(|v[63:31]);
    endfunction

    assign isMul  = start && (ALUCode == MUL_CODE);
    assign isDiv  = start && (ALUCode == DIV_CODE);
    assign accept = reset && (state == IDLE) && (isMul || isDiv) && !flush;

    // The issuing instruction must stall in its own cycle, hence the combinational accept term.
    assign busy         = (state != IDLE) || accept;
    assign result_ready = (state == DONE) && !flush;

    assign magA = magnitude(operandA);
    assign magB = magnitude(operandB);

    assign accNext    = acc + (mplier[0] ? mcand : 64'd0);
    assign prodSigned = applySign64(accNext, negResult);
    assign mulOvf     = ~fitsSigned32(prodSigned);

`ifdef MULTDIV_DIV_EN
    // Partial remainder stays below the divisor (<= 2^31), so a 33-bit trial subtract is exact.
    assign remShift  = {rem, quo[31]};
    assign remDiff   = remShift - {1'b0, divisor};
    assign quoBit    = ~remDiff[32];
    assign remNext   = quoBit ? remDiff[31:0] : remShift[31:0];
    assign quoNext   = {quo[30:0], quoBit};
    assign quoSigned = applySign32(quoNext, negResult);
    assign divOvf    = ~negResult & quoNext[31];
`endif

    // Control stage: state, iteration count and the architecturally visible outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            iterCount <= 5'd0;
            result    <= 32'd0;
            exception <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        iterCount <= 5'd0;
                        if (isMul) begin
                            state <= MUL;
                        end else begin
`ifdef MULTDIV_DIV_EN
                            if (operandB == 32'd0) begin
                                state     <= DONE;
                                result    <= 32'd0;
                                exception <= 1'b1;
                            end else begin
                                state <= DIV;
                            end
`else
                            state     <= DONE;
                            result    <= 32'd0;
                            exception <= 1'b1;
`endif
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        iterCount <= iterCount + 5'd1;
                        if (iterCount == 5'd31) begin
                            state     <= DONE;
                            result    <= prodSigned[31:0];
                            exception <= mulOvf;
                        end
                    end
                end
`ifdef MULTDIV_DIV_EN
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        iterCount <= iterCount + 5'd1;
                        if (iterCount == 5'd31) begin
                            state     <= DONE;
                            result    <= quoSigned;
                            exception <= divOvf;
                        end
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath stage: operand latch on accept, then one multiply or divide step per cycle.
    always_ff @(posedge clock) begin
        if (accept) begin
            negResult <= operandA[31] ^ operandB[31];
            acc       <= 64'd0;
            mcand     <= {32'd0, magA};
            mplier    <= magB;
`ifdef MULTDIV_DIV_EN
            rem       <= 32'd0;
            quo       <= magA;
            divisor   <= magB;
`endif
        end else if (state == MUL) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
`ifdef MULTDIV_DIV_EN
        else if (state == DIV) begin
            rem <= remNext;
            quo <= quoNext;
        end
`endif
    end

endmodule

// File: tb/tb_execute_multdiv.sv
// Bench for execute_multdiv: directed literal cases plus randomized traffic against a cycle-level reference.
// Follows the DUT build: MULTDIV_DIV_EN selects the expected divide behaviour.
module tb_execute_multdiv;

    localparam logic [4:0] MULC = 5'b00110;
    localparam logic [4:0] DIVC = 5'b00111;
`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  ALUCode = 5'd0;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic        busy;
    logic        result_ready;
    logic [31:0] result;
    logic        exception;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    execute_multdiv #(.MUL_CODE(MULC), .DIV_CODE(DIVC)) dut (
        .clock(clock), .reset(reset), .start(start), .ALUCode(ALUCode),
        .operandA(operandA), .operandB(operandB), .flush(flush),
        .busy(busy), .result_ready(result_ready), .result(result), .exception(exception)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the signed-operation definition.
    task automatic refOp(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] r, output logic e);
        longint p;
        longint lim;
        lim = 64'h0000_0000_8000_0000;
        if (code == MULC) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            e   = (p >= lim) || (p < -lim);
            lat = 33;
        end else if (!DIV_EN || b == 32'd0) begin
            r = 32'd0; e = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000; e = 1'b1; lat = 33;
        end else begin
            r = 32'($signed(a) / $signed(b)); e = 1'b0; lat = 33;
        end
    endtask

    // Model: cycles left in the current operation (DONE is the last), visible and pending results.
    int          mLeft = 0;
    logic [31:0] mRes = 32'd0;
    logic [31:0] mPend = 32'd0;
    logic        mExc = 1'b0;
    logic        mPendExc = 1'b0;

    always @(negedge clock) begin
        logic        acc;
        logic        eBusy;
        logic        eRdy;
        logic [31:0] eRes;
        logic        eExc;
        int          lat;
        logic [31:0] r;
        logic        e;
        if (!reset) begin
            acc = 1'b0; eBusy = 1'b0; eRdy = 1'b0; eRes = 32'd0; eExc = 1'b0;
        end else begin
            acc   = (mLeft == 0) && start && (ALUCode == MULC || ALUCode == DIVC) && !flush;
            eBusy = (mLeft > 0) || acc;
            eRdy  = (mLeft == 1) && !flush;
            eRes  = mRes;
            eExc  = mExc;
        end
        chk("busy", {31'd0, busy}, {31'd0, eBusy});
        chk("result_ready", {31'd0, result_ready}, {31'd0, eRdy});
        chk("result", result, eRes);
        chk("exception", {31'd0, exception}, {31'd0, eExc});
        if (!reset) begin
            mLeft = 0; mRes = 32'd0; mExc = 1'b0;
        end else if (mLeft > 0) begin
            if (flush) begin
                mLeft = 0;
            end else begin
                if (mLeft == 2) begin
                    mRes = mPend; mExc = mPendExc;
                end
                mLeft--;
            end
        end else if (acc) begin
            refOp(ALUCode, operandA, operandB, lat, r, e);
            if (lat == 1) begin
                mRes = r; mExc = e; mLeft = 1;
            end else begin
                mPend = r; mPendExc = e; mLeft = 33;
            end
        end
    end

    task automatic doOp(input string nm, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int expLat, input logic [31:0] expRes,
                        input logic expExc);
        int n;
        bit found;
        @(posedge clock); #1;
        start = 1'b1; ALUCode = code; operandA = a; operandB = b;
        @(negedge clock);
        chk({nm, " busy@0"}, {31'd0, busy}, 32'd1);
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        found = 1'b0;
        while (!found && n <= 40) begin
            @(negedge clock);
            if (result_ready) found = 1'b1;
            else begin
                @(posedge clock); #1;
                n++;
            end
        end
        chk({nm, " latency"}, n, expLat);
        chk({nm, " result"}, result, expRes);
        chk({nm, " exception"}, {31'd0, exception}, {31'd0, expExc});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdyCount;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        doOp("mul 7x-6", MULC, 32'd7, 32'hFFFF_FFFA, 33, 32'hFFFF_FFD6, 1'b0);

        // Flush at cycle 10 of a multiply, with an ADD start at cycle 5 while busy.
        @(posedge clock); #1;
        start = 1'b1; ALUCode = MULC; operandA = 32'd5; operandB = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 start = 1'b1; ALUCode = 5'b00000;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush result kept", result, 32'hFFFF_FFD6);
        chk("flush exception kept", {31'd0, exception}, 32'd0);
        rdyCount = 0;
        repeat (35) begin
            @(negedge clock);
            if (result_ready) rdyCount++;
        end
        chk("flush no ready", rdyCount, 0);

        // ADD code while idle is ignored.
        @(posedge clock); #1;
        start = 1'b1; ALUCode = 5'b00000; operandA = 32'd3; operandB = 32'd4;
        @(negedge clock);
        chk("add ignored busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("add ignored next", {31'd0, busy}, 32'd0);

        doOp("mul 2^16x2^16", MULC, 32'h0001_0000, 32'h0001_0000, 33, 32'h0000_0000, 1'b1);
`ifdef MULTDIV_DIV_EN
        doOp("div -7/2", DIVC, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
        doOp("div 5/0", DIVC, 32'd5, 32'd0, 1, 32'd0, 1'b1);
        doOp("div min/-1", DIVC, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1);
        doOp("div 100/7", DIVC, 32'd100, 32'd7, 33, 32'd14, 1'b0);
`else
        doOp("div 10/2 no divider", DIVC, 32'd10, 32'd2, 1, 32'd0, 1'b1);
        doOp("div 5/0 no divider", DIVC, 32'd5, 32'd0, 1, 32'd0, 1'b1);
`endif
        doOp("mul min x1", MULC, 32'h8000_0000, 32'd1, 33, 32'h8000_0000, 1'b0);

        // Reset at cycle 20 of a long operation clears outputs without waiting for a clock.
        @(posedge clock); #1;
        start = 1'b1; ALUCode = DIV_EN ? DIVC : MULC; operandA = 32'd100; operandB = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset ready", {31'd0, result_ready}, 32'd0);
        chk("async reset result", result, 32'd0);
        chk("async reset exception", {31'd0, exception}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        doOp("mul 3x3 after reset", MULC, 32'd3, 32'd3, 33, 32'd9, 1'b0);

        // Randomized traffic; the model process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0, 1:    ALUCode = MULC;
                2, 3:    ALUCode = DIVC;
                default: ALUCode = 5'($urandom);
            endcase
            operandA = pick();
            operandB = pick();
            flush    = ($urandom_range(0, 59) == 0);
            reset    = ($urandom_range(0, 799) != 0);
        end
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0; reset = 1'b1;
        repeat (40) @(posedge clock);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_multdiv.md
# execute_multdiv

Iterative signed multiply/divide unit in the execute stage, directly downstream of the opcode-to-ALU-code decoder. It consumes the 5-bit ALU code and both operands when the decoder yields the MUL or DIV code, and runs a 32-iteration shift-add multiply or restoring divide. While it runs it holds `busy` high so the pipeline stalls. It then returns a 32-bit result with a one-cycle ready pulse and an exception flag for the writeback path.

## Interface
- `MUL_CODE`, default 5'b00110: ALU code that selects multiply.
- `DIV_CODE`, default 5'b00111: ALU code that selects divide.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset; 0 forces reset state immediately.
- `start`  in  1: issue strobe; execute stage holds an R-type instruction.
- `ALUCode`  in  5: decoder output.
- `operandA`, `operandB`  in  32 each: signed two's-complement sources (A op B).
- `flush`  in  1: abort the in-flight operation (branch or jump squash).
- `busy`  out  1: stall request to the pipeline.
- `result_ready`  out  1: one-cycle pulse; `result` is valid.
- `result`  out  32: product low word or quotient.
- `exception`  out  1: valid with `result_ready`.

## Operation
- States: IDLE, MUL, DIV, DONE. There is a 5-bit iteration counter.
- IDLE:
  - Accept when `start` is 1 and `ALUCode` is MUL_CODE or DIV_CODE. Any other code is ignored.
  - On accept, latch both operands, clear the counter and go to MUL or DIV.
  - DIV with `operandB` == 0 goes straight to DONE with `result`=0 and `exception`=1.
- MUL:
  - Multiply the magnitudes with a 64-bit accumulator, one partial product per cycle.
  - After iteration 31, apply the sign (sign = A[31]^B[31]) and go to DONE.
  - `exception`=1 when the signed 64-bit product is outside the range of a 32-bit signed value, i.e. bits [63:31] are not all equal. `result` is the low 32 bits regardless.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign is A[31]^B[31]; truncate toward zero. The remainder is discarded.
  - 0x80000000 / 0xFFFFFFFF gives `result`=0x80000000 and `exception`=1.
- DONE: assert `result_ready` for exactly one cycle, then return to IDLE.
- `result` and `exception` hold their values from DONE until the next accept.
- `start` while `busy` is ignored; there is no queueing.
- Width rules:
  - Magnitude of 0x80000000 is computed as an unsigned 32-bit value 2^31 with no overflow.
  - Internal accumulator is 64 bits; partial remainder is 33 bits.

## Timing
- Reset state:
  - State IDLE, counter 0.
  - `busy`=0, `result_ready`=0, `result`=0, `exception`=0.
- Latency: accept edge at cycle 0.
  - MUL/DIV iterate in cycles 1–32.
  - DONE in cycle 33, with `result_ready`=1 during that cycle.
  - Divide-by-zero reaches DONE at cycle 1.
- `busy` is high from the cycle after accept through DONE inclusive.
  - It is combinationally high in the accept cycle itself (`start` qualified by a valid code in IDLE), so the issuing instruction stalls immediately.
- `flush`:
  - In MUL/DIV/DONE, the next state is IDLE and no `result_ready` is produced.
  - `result` and `exception` keep their previous values.
  - `flush` takes priority over a simultaneous `start` in IDLE; nothing is accepted.
- Reset mid-operation: immediately return to reset state with no pulse. Operation resumes only on a new accept after `reset` returns to 1.
- Back-to-back operation: a new accept is allowed in the cycle after DONE. The earliest second `result_ready` comes 34 cycles after the first.

## Configuration
- `MULTDIV_DIV_EN`:
  - Defined: the divider datapath and DIV state are built as described.
  - Undefined: no divider logic exists. DIV_CODE is accepted and goes straight to DONE with `result`=0 and `exception`=1 (ready at cycle 1). Multiply is unchanged.

## Test plan
- Reset, then MUL 7 × -6 → `busy` high cycles 0–33; `result_ready` at cycle 33 with `result`=0xFFFFFFD6 and `exception`=0.
- MUL 0x00010000 × 0x00010000 → `result`=0x00000000 and `exception`=1. MUL 0x80000000 × 1 → 0x80000000 and `exception`=0.
- DIV -7 / 2 → `result`=0xFFFFFFFD and `exception`=0. DIV 5 / 0 → ready at cycle 1, `result`=0, `exception`=1.
- DIV 0x80000000 / 0xFFFFFFFF → `result`=0x80000000 and `exception`=1. With `MULTDIV_DIV_EN` undefined, DIV 10/2 → ready at cycle 1, `result`=0, `exception`=1.
- `flush` at cycle 10 of a MUL → IDLE next cycle, no `result_ready`, `result` unchanged. `start` at cycle 5 with ADD code (5'b00000) → ignored.
- `reset` low at cycle 20 of a DIV → outputs return to 0 asynchronously. After release, a new MUL 3×3 gives 9 at cycle 33.
